spi_sub_sync: RTL and testbench
===============================

Name: spi_sub_sync

Overview:
- Clocked SPI responder (sub) and counterpart to spi_main; runs on the system clock instead of on sclk.
- Oversamples sclk, cs and mosi through synchronizers, detects sclk edges, and shifts WIDTH-bit words MSB-first in SPI mode 0 (CPOL=0, CPHA=0).
- Gives the user logic a load/ready/done handshake in the clk domain, with a one-word transmit holding buffer.
- Supports back-to-back words within one cs frame.

Parameters:
WIDTH, 8, word length in bits (≥2)
SYNC_STAGES, 2, flip-flop stages on sclk/cs/mosi synchronizers (≥2)
IDLE_TX, 8'hFF, word shifted out when no word is pending in the holding buffer (WIDTH bits)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (reset=0 resets the block)
data_in  input  WIDTH  word to transmit on miso
load  input  1  1-cycle strobe; captures data_in into the holding buffer
data_out  output  WIDTH  last complete word received from mosi
ready  output  1  1 = holding buffer empty
done  output  1  1-cycle pulse: word complete, data_out updated
sclk  input  1  SPI clock from main, asynchronous to clk
cs  input  1  chip select, active-low
mosi  input  1  main-out serial data
miso  output  1  sub-out serial data

Behaviour:
- Reset (reset=0, asynchronous): data_out=0, ready=1, done=0, miso=0, holding buffer=IDLE_TX and marked empty, shift registers=0, bit counter=0, state IDLE, synchronizers=0 except cs sync=1.
- Constraints: sclk high and low phases ≥4 clk each; cs falling to first sclk rise ≥4 clk. Behaviour outside these limits is undefined.
- Synchronized signals: s_sclk, s_cs, s_mosi, delayed SYNC_STAGES clk.
- Edges: rise = s_sclk & ~prev; fall = ~s_sclk & prev.
- load: holding buffer<=data_in, ready<=0 on the next edge.
  - load while ready=0 overwrites the pending word.
  - load in the same cycle as a buffer consume: load wins; the new word stays pending (ready=0); the consumed value is the old pending word.
- Consume: tx_shift<=pending word if ready=0, else IDLE_TX; then ready<=1.
- FSM states: IDLE, SHIFT.
  - IDLE: miso=0. On s_cs falling: consume, bit_cnt<=0, go to SHIFT. miso=tx_shift[WIDTH-1] from the next cycle, i.e. SYNC_STAGES+1 clk after the pin edge.
  - SHIFT, rise: rx_shift<={rx_shift[WIDTH-2:0], s_mosi}; bit_cnt++.
  - SHIFT, rise and bit_cnt==WIDTH-1: data_out<={rx_shift[WIDTH-2:0],s_mosi}; done=1 for exactly one cycle, registered, asserted the cycle after the edge is detected; bit_cnt<=0; set the reload flag.
  - SHIFT, fall: if reload flag, consume (next word MSB on miso), clear the flag; else tx_shift<<=1. miso always = tx_shift[WIDTH-1].
  - SHIFT, s_cs high: return to IDLE.
    - Partial word (bit_cnt≠0): discarded; no done; data_out unchanged.
    - Holding buffer not touched.
    - A pending reload flag is cleared with no consume.
- Rise and s_cs rising in the same cycle: cs wins; the rise is ignored.
- sclk edges while in IDLE are ignored.
- bit_cnt width = clog2(WIDTH); it never exceeds WIDTH-1.

Optional Feature:
- Macro SPI_SUB_SYNC_MISO_TRI_EN.
- Defined: miso=1'bz whenever the synchronized cs is high (state IDLE), for a shared-bus multi-sub topology.
- Undefined: miso is driven 0 in IDLE.
- SHIFT behaviour is identical in both cases.

Test Plan:
1. Reset: hold reset=0 with cs=1 and sclk toggling -> data_out=0, ready=1, done=0, miso=0, and all stay so for 20 cycles.
2. Single word: load data_in=8'hA5; then main frame with mosi=8'h3C, sclk 8 clk/period -> ready 1->0 on load, back to 1 at cs fall; miso carries 10100101; one done pulse; data_out=8'h3C.
3. Empty buffer: frame of 8 bits with no prior load -> miso=8'hFF, done pulses once, data_out=received byte.
4. Back-to-back: load 8'hC3, then load 8'h81 after the first consume; 16-bit frame with mosi=8'h12,8'h34 -> miso C3 then 81; two done pulses; data_out 8'h12 then 8'h34.
5. Abort: cs rises after 5 bits of 8'hF0 -> no done; data_out keeps its previous value; next full frame with 8'h0F gives data_out=8'h0F.
6. Async reset mid-frame: drive reset=0 after 3 bits -> outputs return to reset values immediately, not waiting for a clk edge; the frame after release works normally.

Source files
------------

// File: rtl/spi_sub_sync.sv
// -----------------------------------------------------------------------------
// spi_sub_sync
//
// SPI responder (sub) for SPI mode 0 (CPOL=0, CPHA=0). It runs on the system
// clock and oversamples sclk, cs and mosi through flip-flop synchronizers.
// Words are WIDTH bits long and travel MSB-first. Several words may follow
// each other inside one cs frame.
//
// Transmit handshake (clk domain):
//   ready=1 means the one-word holding buffer is empty. A 1-cycle load strobe
//   captures data_in into the buffer and drops ready on the next edge. Loading
//   while ready=0 overwrites the pending word. At the start of each word the
//   buffer is consumed: the pending word is used if ready=0, otherwise
//   IDLE_TX, and ready returns to 1. If load and consume coincide, load wins:
//   the old pending word is shifted out and the new one stays pending.
//   done is a 1-cycle pulse marking that data_out holds a newly completed word.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   data_in   word to transmit on miso
//   load      1-cycle strobe; captures data_in into the holding buffer
//   data_out  last complete word received on mosi
//   ready     1 = holding buffer empty
//   done      1-cycle pulse: word complete, data_out updated
//   sclk      SPI clock from the main; asynchronous to clk
//   cs        chip select, active-low
//   mosi      main-out serial data
//   miso      sub-out serial data
//
// Optional feature:
//   SPI_SUB_SYNC_MISO_TRI_EN -- when defined, miso is released (1'bz) while the
//   block is idle, which lets several subs share one miso line. When it is
//   not defined, miso is driven 0 while idle.
//
// Debug: the FSM state is held in state_q (type state_t).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_sub_sync #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_TX     = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    output logic             done,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Synchronizers. The cs chain resets high, so a cs already held low when
    // reset is released still shows up as a falling edge.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic s_sclk;
    logic s_cs;
    logic s_mosi;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;

    // Datapath registers
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] hold_buf;
    logic [CNT_W-1:0] bit_cnt;
    logic             reload;

    // FSM control strobes
    logic start;      // frame start: consume and clear the counter
    logic consume;    // load tx_shift from the holding buffer (or IDLE_TX)
    logic shift_rx;   // sample mosi on an sclk rise
    logic word_end;   // the sampled bit completes a word
    logic shift_tx;   // advance tx_shift on an sclk fall
    logic leave;      // cs went high: abandon the frame

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= s_sclk;
            cs_prev   <= s_cs;
        end
    end

    assign s_sclk    = sclk_sync[SYNC_STAGES-1];
    assign s_cs      = cs_sync[SYNC_STAGES-1];
    assign s_mosi    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = s_sclk & ~sclk_prev;
    assign sclk_fall = ~s_sclk & sclk_prev;
    assign cs_fall   = ~s_cs & cs_prev;
    assign rx_next   = {rx_shift, s_mosi};

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and strobes. cs going high takes priority over any
    // sclk edge seen in the same cycle.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        consume  = 1'b0;
        shift_rx = 1'b0;
        word_end = 1'b0;
        shift_tx = 1'b0;
        leave    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    start   = 1'b1;
                    consume = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (s_cs) begin
                    leave   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                    word_end = (bit_cnt == LAST_BIT);
                end else if (sclk_fall) begin
                    if (reload) begin
                        consume = 1'b1;
                    end else begin
                        shift_tx = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_shift <= '0;
            tx_shift <= '0;
            hold_buf <= IDLE_TX;
            ready    <= 1'b1;
            bit_cnt  <= '0;
            reload   <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;

            if (start || leave) begin
                // A partial word is dropped and a pending reload is forgotten.
                bit_cnt <= '0;
                reload  <= 1'b0;
            end else if (shift_rx) begin
                rx_shift <= rx_next[WIDTH-2:0];
                if (word_end) begin
                    data_out <= rx_next;
                    done     <= 1'b1;
                    bit_cnt  <= '0;
                    reload   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (consume) begin
                reload <= 1'b0;
            end

            // The next word's MSB is loaded on the fall that ends the
            // previous word, so it is on miso before the main samples it.
            if (consume) begin
                tx_shift <= ready ? IDLE_TX : hold_buf;
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end

            if (load) begin
                hold_buf <= data_in;
                ready    <= 1'b0;
            end else if (consume) begin
                ready <= 1'b1;
            end
        end
    end

`ifdef SPI_SUB_SYNC_MISO_TRI_EN
    assign miso = (state_q == SHIFT) ? tx_shift[WIDTH-1] : 1'bz;
`else
    assign miso = (state_q == SHIFT) ? tx_shift[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_sub_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_sub_sync
//
// Directed bench for spi_sub_sync. A mode-0 SPI main is driven from tasks with
// an 8-clk sclk period. Every full word the main sends is queued as an
// expected receive word; a compare process checks data_out, done and the
// reset values on every falling clk edge against that queue. Transmitted
// words and done counts are compared with hand-computed literals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_sub_sync;

    localparam int WIDTH = 8;

`ifdef SPI_SUB_SYNC_MISO_TRI_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic [WIDTH-1:0] data_out;
    logic             ready;
    logic             done;
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic             miso;

    always #5 clk = ~clk;

    spi_sub_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2),
        .IDLE_TX    (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .load    (load),
        .data_out(data_out),
        .ready   (ready),
        .done    (done),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso)
    );

    // ---------------- scoreboard ----------------
    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_done   = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] model_dout = '0;
    logic             prev_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            exp_q.delete();
            model_dout = '0;
            prev_done  = 1'b0;
            check("rst_data_out", data_out, 0);
            check("rst_ready", ready, 1);
            check("rst_done", done, 0);
            check("rst_miso", miso, MISO_IDLE);
        end else begin
            if (done === 1'b1) begin
                n_done++;
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) model_dout = exp_q.pop_front();
            end
            check("done_single_cycle", done & prev_done, 0);
            check("data_out", data_out, model_dout);
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [WIDTH-1:0] d);
        @(negedge clk);
        data_in = d;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Mode-0 frame of nbits bits, first bit = bits[nbits-1]. miso is sampled
    // at each sclk rise. Full words are queued as expected receive words
    // when push is set.
    task automatic spi_frame(input logic [31:0] bits, input int nbits, input bit push,
                             output logic [31:0] got);
        logic [31:0] tmp;
        got = '0;
        if (push) begin
            for (int k = 0; k < nbits / WIDTH; k++) begin
                tmp = bits >> (nbits - WIDTH * (k + 1));
                exp_q.push_back(tmp[WIDTH-1:0]);
            end
        end
        @(negedge clk);
        cs   = 1'b0;
        mosi = bits[nbits-1];
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            got  = {got[30:0], miso};
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            if (i < nbits - 1) mosi = bits[nbits-2-i];
            repeat (4) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] got;
        int          d0;
        int          waited;

        reset   = 1'b1;
        cs      = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        load    = 1'b0;
        data_in = '0;
        #1 reset = 1'b0;

        // 1. reset held with sclk toggling
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            sclk = ~sclk;
        end
        sclk = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t1_ready", ready, 1);
        check("t1_miso_idle", miso, MISO_IDLE);
        check("t1_data_out", data_out, 8'h00);

        // 2. single word with a preloaded transmit word
        do_load(8'hA5);
        check("t2_ready_after_load", ready, 0);
        d0 = n_done;
        spi_frame(32'h3C, 8, 1'b1, got);
        check("t2_miso_word", got[7:0], 8'hA5);
        check("t2_done_count", n_done - d0, 1);
        check("t2_data_out", data_out, 8'h3C);
        check("t2_ready_after_frame", ready, 1);
        check("t2_miso_idle", miso, MISO_IDLE);

        // 3. empty holding buffer sends IDLE_TX
        d0 = n_done;
        spi_frame(32'h96, 8, 1'b1, got);
        check("t3_miso_word", got[7:0], 8'hFF);
        check("t3_done_count", n_done - d0, 1);
        check("t3_data_out", data_out, 8'h96);

        // 4. back-to-back words in one frame, second word loaded mid-frame
        do_load(8'hC3);
        check("t4_ready_after_load", ready, 0);
        d0 = n_done;
        fork
            spi_frame(32'h1234, 16, 1'b1, got);
            begin
                waited = 0;
                while (ready !== 1'b1 && waited < 60) begin
                    @(negedge clk);
                    waited++;
                end
                check("t4_first_consume", ready, 1);
                do_load(8'h81);
                check("t4_ready_second_load", ready, 0);
            end
        join
        check("t4_miso_words", got[15:0], 16'hC381);
        check("t4_done_count", n_done - d0, 2);
        check("t4_data_out", data_out, 8'h34);
        check("t4_ready_after_frame", ready, 1);

        // 5. aborted frame after 5 bits, then a full frame
        d0 = n_done;
        spi_frame(32'h1E, 5, 1'b0, got);
        check("t5_abort_done_count", n_done - d0, 0);
        check("t5_abort_data_out", data_out, 8'h34);
        check("t5_abort_miso_bits", got[4:0], 5'h1F);
        check("t5_abort_ready", ready, 1);
        d0 = n_done;
        spi_frame(32'h0F, 8, 1'b1, got);
        check("t5_done_count", n_done - d0, 1);
        check("t5_data_out", data_out, 8'h0F);
        check("t5_miso_word", got[7:0], 8'hFF);

        // 6. asynchronous reset in the middle of a frame
        d0 = n_done;
        fork
            spi_frame(32'hAA, 8, 1'b0, got);
            begin
                repeat (20) @(negedge clk);
                do_load(8'h77);
                check("t6_ready_before_reset", ready, 0);
                repeat (8) @(negedge clk);
                #2 reset = 1'b0;
                #1;
                check("t6_async_data_out", data_out, 8'h00);
                check("t6_async_ready", ready, 1);
                check("t6_async_done", done, 0);
                check("t6_async_miso", miso, MISO_IDLE);
            end
        join
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_done_during_reset", n_done - d0, 0);
        d0 = n_done;
        spi_frame(32'h5A, 8, 1'b1, got);
        check("t6_done_count", n_done - d0, 1);
        check("t6_data_out", data_out, 8'h5A);
        check("t6_miso_word", got[7:0], 8'hFF);
        check("t6_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
